btn_arbiter: RTL

Round-robin scheduler sharing a single command-consuming resource (counter, display or FSM) among N push-button channels. Each channel's level input is rising-edge detected, latched as a pending request, and presented to the resource one at a time over a valid/ready handshake. This block sits between the synchronized/debounced button inputs and the shared datapath.

---
 rtl/btn_arbiter_pkg.sv | 31 +++
 rtl/btn_arbiter_edge.sv | 21 ++
 rtl/btn_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/btn_arbiter_pkg.sv
// Shared FSM encoding and the round-robin search used by btn_arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package btn_arbiter_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_OFFER = 1'b1;

  // First set bit of req at or after start, wrapping at n (n <= 32).
  // Returns start when req has no bit set below n.
  function automatic logic [31:0] rr_search(input logic [31:0] req,
                                            input logic [31:0] start,
                                            input logic [31:0] n);
    logic [31:0] idx;
    logic        found;
    rr_search = start;
    found     = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((k < n) && !found) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (((req >> idx) & 32'd1) != 32'd0) begin
          rr_search = idx;
          found     = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/btn_arbiter_edge.sv
// Single-channel rising-edge detector; previous-level register resets high.
// Latency: rise is combinational from d against the previous-cycle level.
// Backpressure: none; a level held through reset never produces a rise.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  // Remember last cycle's level; reset high so held buttons are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b1;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/btn_arbiter.sv
// Round-robin scheduler of N button channels onto one valid/ready command port.
// Latency: press to pending 1 cycle, pending to offer 1 more; one command per 2 cycles.
// Backpressure: out_id held while out_ready low; repeat presses merge and pulse overrun.
module btn_arbiter
  import btn_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    btn,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  input  logic            out_ready,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  logic [N-1:0]    rise;
  logic [N-1:0]    acc_vec;
  logic [N-1:0]    pend_nxt;
  logic [N-1:0]    ov_nxt;
  logic [ID_W-1:0] ptr;
  logic            acc;
  state_t          state;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_edge
      edge_pulse u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn[g]),
        .rise (rise[g])
      );
    end
  endgenerate

  assign out_valid = (state == ST_OFFER);
  assign acc       = out_valid & out_ready;

  // Per-channel request update: a fresh press always leaves the bit set,
  // an accept without a press clears it, a press on a waiting bit is an overrun.
  always_comb begin
    acc_vec  = '0;
    pend_nxt = '0;
    ov_nxt   = '0;
    for (int i = 0; i < N; i++) begin
      acc_vec[i]  = acc && (out_id == ID_W'(i));
      pend_nxt[i] = rise[i] | (pending[i] & ~acc_vec[i]);
      ov_nxt[i]   = rise[i] & pending[i] & ~acc_vec[i];
    end
  end

  // Pending requests and the one-cycle overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= pend_nxt;
      overrun <= ov_nxt;
    end
  end

  // Offer FSM: pick from registered pending only, advance ptr past the accepted id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      out_id <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            state  <= ST_OFFER;
            out_id <= ID_W'(rr_search(32'(pending), 32'(ptr), 32'(N)));
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            state <= ST_IDLE;
            ptr   <= (out_id == ID_W'(N - 1)) ? '0 : out_id + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
